// File: rtl/layer_hidden_act_sequencer.sv
// layer_hidden_act_sequencer
//   Walks the hidden layer's pre-activation values one neuron at a time.
//   For each neuron it reads the two bracketing LUT samples from a
//   single-port synchronous ROM, presents them to a shared external linear
//   interpolator and writes the interpolated result back to the output
//   register file. Each neuron takes four cycles: RD_BASE, RD_NEXT, LATCH,
//   WRITE.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             begin a layer (only honoured in IDLE)
//   busy, done        status: busy outside IDLE, done pulses after last write
//   z_idx / z_data    pre-activation register file read (combinational)
//   lut_en / lut_addr LUT read request; lut_data returns one cycle later
//   ip_remaining/ip_base/ip_next  registered interpolator operands
//   ip_value          interpolator result (combinational from ip_*)
//   out_we/out_idx/out_data  result write port
module layer_hidden_act_sequencer #(
    parameter int NEURONS = 4,
    parameter int DATA_W  = 8,
    parameter int FRAC_W  = 4,
    parameter int IDX_W   = (NEURONS > 1) ? $clog2(NEURONS) : 1,
    parameter int LUT_AW  = DATA_W - FRAC_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  z_idx,
    input  logic [DATA_W-1:0] z_data,
    output logic              lut_en,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    output logic [DATA_W-1:0] ip_remaining,
    output logic [DATA_W-1:0] ip_base,
    output logic [DATA_W-1:0] ip_next,
    input  logic [DATA_W-1:0] ip_value,
    output logic              out_we,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data
);

    localparam int SEG_W = DATA_W - FRAC_W;
    // Flipping the sign bit turns the signed segment into offset binary,
    // so the most negative input maps to LUT entry 0.
    localparam logic [SEG_W-1:0] SEG_MSB  = SEG_W'(1) << (SEG_W - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE, RD_BASE, RD_NEXT, LATCH, WRITE, DONE
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] z_reg;
    logic [DATA_W-1:0] base_reg;
    logic              we_reg;

    // Segment is widened before the +1 so the upper sample of the top
    // segment lands on the extra table entry instead of wrapping to 0.
    function automatic logic [LUT_AW-1:0] seg_of(input logic [DATA_W-1:0] z);
        return LUT_AW'(z[DATA_W-1:FRAC_W] ^ SEG_MSB);
    endfunction

    // Base address must be issued in the same cycle z_data is read, so the
    // address is a decode of the state rather than a register.
    always_comb begin
        lut_addr = '0;
        case (state)
            RD_BASE: lut_addr = seg_of(z_data);
            RD_NEXT: lut_addr = seg_of(z_reg) + LUT_AW'(1);
            default: lut_addr = '0;
        endcase
    end

    assign z_idx    = idx;
    assign out_idx  = idx;
    assign out_data = ip_value;
    // A reset landing on the WRITE cycle cancels that write.
    assign out_we   = we_reg & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            z_reg        <= '0;
            base_reg     <= '0;
            we_reg       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            lut_en       <= 1'b0;
            ip_remaining <= '0;
            ip_base      <= '0;
            ip_next      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        idx    <= '0;
                        busy   <= 1'b1;
                        lut_en <= 1'b1;
                        state  <= RD_BASE;
                    end
                end
                RD_BASE: begin
                    z_reg <= z_data;
                    state <= RD_NEXT;
                end
                RD_NEXT: begin
                    base_reg <= lut_data;
                    lut_en   <= 1'b0;
                    state    <= LATCH;
                end
                LATCH: begin
                    // Upper sample arrives this cycle and goes straight to
                    // the interpolator operand register.
                    ip_next      <= lut_data;
                    ip_base      <= base_reg;
                    ip_remaining <= {{SEG_W{1'b0}}, z_reg[FRAC_W-1:0]};
                    we_reg       <= 1'b1;
                    state        <= WRITE;
                end
                WRITE: begin
                    we_reg <= 1'b0;
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx    <= idx + 1'b1;
                        lut_en <= 1'b1;
                        state  <= RD_BASE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_hidden_act_sequencer.sv
// Directed bench for layer_hidden_act_sequencer: NEURONS=4 instance plus a
// NEURONS=1 instance, behavioural LUT ROM and interpolator models.
module tb_layer_hidden_act_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         lut_mode = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] lut_fn(input logic [4:0] a);
        if (lut_mode == 0) return 8'(4 * int'(a));
        return 8'(64 - 4 * int'(a));
    endfunction

    function automatic logic [7:0] interp(input logic [7:0] b, input logic [7:0] n,
                                          input logic [7:0] r);
        int bi, ni, p;
        bi = int'($signed(b));
        ni = int'($signed(n));
        p  = (ni - bi) * int'(r);
        return 8'(bi + (p >>> 4));
    endfunction

    // ---------------- NEURONS=4 instance ----------------
    logic       start = 1'b0;
    logic       busy, done, lut_en, out_we;
    logic [1:0] z_idx, out_idx;
    logic [7:0] z_data, lut_data = 8'd0, ip_remaining, ip_base, ip_next, ip_value, out_data;
    logic [4:0] lut_addr;
    logic [7:0] zmem [4];

    assign z_data   = zmem[z_idx];
    assign ip_value = interp(ip_base, ip_next, ip_remaining);
    always @(posedge clk) if (lut_en) lut_data <= lut_fn(lut_addr);

    layer_hidden_act_sequencer #(.NEURONS(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .z_idx(z_idx), .z_data(z_data), .lut_en(lut_en), .lut_addr(lut_addr),
        .lut_data(lut_data), .ip_remaining(ip_remaining), .ip_base(ip_base),
        .ip_next(ip_next), .ip_value(ip_value), .out_we(out_we),
        .out_idx(out_idx), .out_data(out_data)
    );

    // ---------------- NEURONS=1 instance ----------------
    logic       start1 = 1'b0;
    logic       busy1, done1, lut_en1, out_we1;
    logic [0:0] z_idx1, out_idx1;
    logic [7:0] z_data1, lut_data1 = 8'd0, ip_rem1, ip_base1, ip_next1, ip_value1, out_data1;
    logic [4:0] lut_addr1;

    assign z_data1   = 8'h18;
    assign ip_value1 = interp(ip_base1, ip_next1, ip_rem1);
    always @(posedge clk) if (lut_en1) lut_data1 <= lut_fn(lut_addr1);

    layer_hidden_act_sequencer #(.NEURONS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .z_idx(z_idx1), .z_data(z_data1), .lut_en(lut_en1), .lut_addr(lut_addr1),
        .lut_data(lut_data1), .ip_remaining(ip_rem1), .ip_base(ip_base1),
        .ip_next(ip_next1), .ip_value(ip_value1), .out_we(out_we1),
        .out_idx(out_idx1), .out_data(out_data1)
    );

    // ---------------- per-cycle capture ----------------
    int we_h[64], wi_h[64], wd_h[64], en_h[64], ad_h[64], dn_h[64], bs_h[64];
    int ipb_h[64], ipn_h[64], ipr_h[64], ipb2_h[64], ipn2_h[64], ipr2_h[64];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Cycle 0 is the cycle in which start is presented to the IDLE block.
    task automatic run(input int ncyc, input bit hold, input int rst_at);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            start = hold || (c == 0);
            rst   = (c == rst_at);
            #1;
            we_h[c]  = int'(out_we);   wi_h[c]  = int'(out_idx);  wd_h[c]  = int'(out_data);
            en_h[c]  = int'(lut_en);   ad_h[c]  = int'(lut_addr); dn_h[c]  = int'(done);
            bs_h[c]  = int'(busy);
            ipb_h[c] = int'(ip_base);  ipn_h[c] = int'(ip_next);  ipr_h[c] = int'(ip_remaining);
            @(negedge clk);
            ipb2_h[c] = int'(ip_base); ipn2_h[c] = int'(ip_next); ipr2_h[c] = int'(ip_remaining);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // Expected trace for z = {00,18,80,7F} with lut[k]=4k.
    task automatic check_std(input string tag);
        int wr_c [4] = '{4, 8, 12, 16};
        int wr_d [4] = '{32, 38, 0, 63};
        int ad_c [8] = '{1, 2, 5, 6, 9, 10, 13, 14};
        int ad_e [8] = '{8, 9, 9, 10, 0, 1, 15, 16};
        int nen;
        nen = 0;
        for (int c = 0; c < 20; c++) begin
            chk({tag, "_we"}, we_h[c], int'(c == 4 || c == 8 || c == 12 || c == 16));
            chk({tag, "_done"}, dn_h[c], int'(c == 17));
            nen += en_h[c];
        end
        for (int k = 0; k < 4; k++) begin
            chk({tag, "_widx"}, wi_h[wr_c[k]], k);
            chk({tag, "_wdata"}, wd_h[wr_c[k]], wr_d[k]);
        end
        for (int k = 0; k < 8; k++) begin
            chk({tag, "_lut_en"}, en_h[ad_c[k]], 1);
            chk({tag, "_lut_addr"}, ad_h[ad_c[k]], ad_e[k]);
        end
        chk({tag, "_lut_reads"}, nen, 8);
        chk({tag, "_ip_base"}, ipb_h[8], 36);
        chk({tag, "_ip_next"}, ipn_h[8], 40);
        chk({tag, "_ip_rem"}, ipr_h[8], 8);
        chk({tag, "_busy_run"}, bs_h[17], 1);
        chk({tag, "_busy_end"}, bs_h[18], 0);
    endtask

    initial begin
        zmem = '{8'h00, 8'h18, 8'h80, 8'h7F};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(out_we), 0);
        chk("rst_lut_en", int'(lut_en), 0);
        chk("rst_lut_addr", int'(lut_addr), 0);
        chk("rst_z_idx", int'(z_idx), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_ip_rem", int'(ip_remaining), 0);
        chk("rst_ip_base", int'(ip_base), 0);
        chk("rst_ip_next", int'(ip_next), 0);
        chk("rst_busy1", int'(busy1), 0);
        rst = 1'b0;
        @(posedge clk);

        // Basic layer
        run(20, 1'b0, -1);
        check_std("basic");

        // start held high: back-to-back runs, one IDLE cycle between
        run(40, 1'b1, -1);
        for (int c = 0; c < 40; c++) begin
            chk("hold_we", we_h[c], int'(c == 4 || c == 8 || c == 12 || c == 16 ||
                                         c == 22 || c == 26 || c == 30 || c == 34));
            chk("hold_done", dn_h[c], int'(c == 17 || c == 35));
        end
        chk("hold_idle_gap", bs_h[18], 0);
        chk("hold_restart", bs_h[19], 1);
        chk("hold_rd_base_addr", ad_h[19], 8);
        begin
            int left;
            left = 40;
            while (busy && left > 0) begin
                @(posedge clk); #2;
                left--;
            end
            chk("hold_drain", int'(busy), 0);
        end

        // Reset landing on the second write cycle
        run(12, 1'b0, 8);
        chk("rst_w0", we_h[4], 1);
        chk("rst_w0_data", wd_h[4], 32);
        chk("rst_w1_cancel", we_h[8], 0);
        for (int c = 9; c < 12; c++) begin
            chk("rst_no_we", we_h[c], 0);
            chk("rst_no_done", dn_h[c], 0);
            chk("rst_no_lut", en_h[c], 0);
        end
        chk("rst_busy_after", bs_h[9], 0);

        // start coincident with reset is dropped
        run(3, 1'b0, 0);
        chk("rst_start_busy1", bs_h[1], 0);
        chk("rst_start_busy2", bs_h[2], 0);
        chk("rst_start_lut", en_h[1], 0);

        // Full run after reset
        run(20, 1'b0, -1);
        check_std("after_rst");

        // Negative slope: lut[k]=64-4k, z=0x08 -> base 32, next 28, rem 8, out 30
        lut_mode = 1;
        zmem = '{8'h08, 8'h08, 8'h08, 8'h08};
        run(20, 1'b0, -1);
        chk("neg_we", we_h[4], 1);
        chk("neg_ip_base", ipb_h[4], 32);
        chk("neg_ip_next", ipn_h[4], 28);
        chk("neg_ip_rem", ipr_h[4], 8);
        chk("neg_data", wd_h[4], 30);
        chk("neg_data_model", wd_h[4], int'(interp(8'(ipb_h[4]), 8'(ipn_h[4]), 8'(ipr_h[4]))));
        chk("neg_ip_base_late", ipb2_h[4], 32);
        chk("neg_ip_next_late", ipn2_h[4], 28);
        chk("neg_ip_rem_late", ipr2_h[4], 8);
        chk("neg_last_data", wd_h[16], 30);

        // NEURONS=1 instance, z=0x18 with lut[k]=4k -> 38
        lut_mode = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            start1 = (c == 0);
            #1;
            chk("n1_we", int'(out_we1), int'(c == 4));
            chk("n1_done", int'(done1), int'(c == 5));
            chk("n1_zidx", int'(z_idx1), 0);
            if (c == 4) begin
                chk("n1_idx", int'(out_idx1), 0);
                chk("n1_data", int'(out_data1), 38);
            end
        end
        start1 = 1'b0;
        chk("n1_busy_end", int'(busy1), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
